// File: rtl/risc_v_defines.sv
// Shared definitions for the data-memory path: funct3 access codes,
// controller state encodings and default parameter values.
package risc_v_defines;

    localparam int MEM_WIDTH_DEF       = 8;
    localparam int DMEM_ADDR_WIDTH_DEF = 10;
    localparam int REG_WIDTH_DEF       = 32;
    localparam int DMEM_DEPTH_DEF      = 1024;
    localparam int RD_LATENCY_DEF      = 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Access size in bytes for a funct3/direction pair; 0 marks an illegal code.
    function automatic logic [2:0] f3_size(input logic [2:0] funct3, input logic we);
        logic [2:0] size;
        size = 3'd0;
        case (funct3)
            F3_B:    size = 3'd1;
            F3_H:    size = 3'd2;
            F3_W:    size = 3'd4;
            F3_BU:   size = we ? 3'd0 : 3'd1;
            F3_HU:   size = we ? 3'd0 : 3'd2;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Response delay line: RD_LATENCY stages of {valid, err, rdata}.
// Entries are cleared synchronously so no response survives a reset.
module dmem_rsp_pipe
    import risc_v_defines::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    input  logic                 i_err,
    input  logic [REG_WIDTH-1:0] i_rdata,
    output logic                 o_valid,
    output logic                 o_err,
    output logic [REG_WIDTH-1:0] o_rdata
);

    logic                 r_valid [RD_LATENCY];
    logic                 r_err   [RD_LATENCY];
    logic [REG_WIDTH-1:0] r_rdata [RD_LATENCY];

    // Shift every stage by one per cycle; stage 0 captures the accepted request.
    // NOTE: clocked state uses non-blocking assignments so all stages read the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_valid[i] <= 1'b0;
                r_err[i]   <= 1'b0;
                r_rdata[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_err;
            r_rdata[0] <= i_rdata;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_err   = r_err[RD_LATENCY-1];
    assign o_rdata = r_rdata[RD_LATENCY-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with RV32I load/store semantics.
// After reset the array is swept to zero one word per cycle (INIT), then
// requests are accepted one per cycle (RUN) with in-order delayed responses.
module dmem_ctrl
    import risc_v_defines::*;
#(
    parameter int MEM_WIDTH       = MEM_WIDTH_DEF,
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int REG_WIDTH       = REG_WIDTH_DEF,
    parameter int DMEM_DEPTH      = DMEM_DEPTH_DEF,
    parameter int RD_LATENCY      = RD_LATENCY_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       rsp_valid,
    output logic [REG_WIDTH-1:0]       rsp_rdata,
    output logic                       rsp_err
);

    localparam int WORDS = DMEM_DEPTH / 4;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW1   = DMEM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CW-1:0]        r_clr_cnt;
    logic                 w_clear_en;
    logic [MEM_WIDTH-1:0] r_mem [DMEM_DEPTH];

    logic [2:0]           w_size;
    logic                 w_f3_bad;
    logic                 w_misal;
    logic                 w_oor;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_wr_en;
    logic [AW1-1:0]       w_end;
    logic [MEM_WIDTH-1:0] w_rd_bytes [4];
    logic [REG_WIDTH-1:0] w_load;
    logic [REG_WIDTH-1:0] w_rsp_data;

    // State register: reset always restarts the clearing sweep.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last word has been cleared.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_clr_cnt == LAST_WORD) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // State outputs: sweep in INIT, accept requests in RUN, nothing while reset is held.
    always_comb begin
        req_ready  = 1'b0;
        w_clear_en = 1'b0;
        case (r_state)
            ST_INIT: w_clear_en = reset_n;
            ST_RUN:  req_ready  = reset_n;
            default: ;
        endcase
    end

    // Clear counter: word index being zeroed during INIT.
    always_ff @(posedge clk) begin
        if (!reset_n)                r_clr_cnt <= '0;
        else if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + CW'(1);
    end

    assign w_size   = f3_size(req_funct3, req_we);
    assign w_f3_bad = (w_size == 3'd0);
    assign w_misal  = ((w_size == 3'd2) && req_addr[0]) ||
                      ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign w_end    = {1'b0, req_addr} + AW1'(w_size);
    assign w_oor    = (w_end > AW1'(DMEM_DEPTH));
    assign w_err    = w_f3_bad | w_misal | w_oor;
    assign w_accept = req_valid & req_ready;
    assign w_wr_en  = w_accept & req_we & ~w_err;

    // Read the four bytes from the request address; lanes past the array end read 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_rd_bytes[i] = '0;
            if (({1'b0, req_addr} + AW1'(i)) < AW1'(DMEM_DEPTH))
                w_rd_bytes[i] = r_mem[req_addr + DMEM_ADDR_WIDTH'(i)];
        end
    end

    // Assemble the little-endian load value and extend it to register width.
    always_comb begin
        w_load = '0;
        case (req_funct3)
            F3_B:    w_load = REG_WIDTH'($signed(w_rd_bytes[0]));
            F3_H:    w_load = REG_WIDTH'($signed({w_rd_bytes[1], w_rd_bytes[0]}));
            F3_W:    w_load = REG_WIDTH'({w_rd_bytes[3], w_rd_bytes[2], w_rd_bytes[1], w_rd_bytes[0]});
            F3_BU:   w_load = REG_WIDTH'(w_rd_bytes[0]);
            F3_HU:   w_load = REG_WIDTH'({w_rd_bytes[1], w_rd_bytes[0]});
            default: w_load = '0;
        endcase
    end

    assign w_rsp_data = (w_accept && !req_we && !w_err) ? w_load : '0;

    // Array write: INIT sweep zeroes one word, otherwise a legal store writes its byte lanes.
    // NOTE: the array has no reset term; its contents are defined by the INIT sweep instead.
    always_ff @(posedge clk) begin
        if (w_clear_en) begin
            for (int i = 0; i < 4; i++)
                r_mem[DMEM_ADDR_WIDTH'({r_clr_cnt, 2'(i)})] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (3'(i) < w_size)
                    r_mem[req_addr + DMEM_ADDR_WIDTH'(i)] <= req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
        end
    end

    dmem_rsp_pipe #(
        .REG_WIDTH  (REG_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_accept),
        .i_err   (w_accept & w_err),
        .i_rdata (w_rsp_data),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_rdata (rsp_rdata)
    );

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Byte-addressable data memory for the RISC-V core with RV32I load/store semantics: byte/half/word access sizes, sign/zero extension, misalignment and range error detection, and a valid/ready request port with in-order responses after a parametrised read latency. It replaces the fixed word-only data memory behind the MEM stage. After reset it clears its array one word per cycle, and holds off requests until clearing is done.

## Interface
- MEM_WIDTH, 8: bits per memory location (byte).
- DMEM_ADDR_WIDTH, 10: byte address width.
- REG_WIDTH, 32: data word width.
- DMEM_DEPTH, 1024: number of bytes. Must be a multiple of 4.
- RD_LATENCY, 1: cycles from request acceptance to response. Legal range is 1..4.

- clk, input, 1: single clock. All logic is rising-edge.
- reset_n, input, 1: reset, synchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: request can be accepted. Accept = req_valid && req_ready at a rising edge.
- req_we, input, 1: 1 = store, 0 = load.
- req_funct3, input, 3: access type, RV32I funct3 encoding.
- req_addr, input, DMEM_ADDR_WIDTH: byte address.
- req_wdata, input, REG_WIDTH: store data. Only the low byte or half is used for SB/SH.
- rsp_valid, output, 1: response present for one cycle. There is no backpressure on responses.
- rsp_rdata, output, REG_WIDTH: load result, already extended. It is 0 for stores and for errors.
- rsp_err, output, 1: the request was rejected (misaligned, out of range, or illegal funct3).

## Operation
- States are INIT and RUN.
  - Reset forces INIT and sets the clear counter to 0.
  - In INIT, one aligned word (4 bytes at counter*4) is zeroed per cycle. After DMEM_DEPTH/4 cycles the block moves to RUN.
  - req_ready = 0 in INIT and 1 in RUN.
- funct3 decode:
  - 000 = LB/SB
  - 001 = LH/SH
  - 010 = LW/SW
  - 100 = LBU
  - 101 = LHU
  - 100 or 101 with req_we = 1 is illegal. Codes 011, 110 and 111 are always illegal.
- Error conditions. Any of the following gives rsp_err = 1, no memory change, and rsp_rdata = 0:
  - half access with addr[0] != 0;
  - word access with addr[1:0] != 0;
  - addr + size > DMEM_DEPTH;
  - illegal funct3.
- Stores: the addressed bytes are written little-endian at the acceptance edge. Bytes outside the access size are untouched.
- Loads: bytes are read little-endian at the acceptance edge, then sign-extended (LB, LH) or zero-extended (LBU, LHU) to REG_WIDTH.
- Every accepted request, load or store, produces exactly one response. Responses are in order.

## Timing
- Output values during reset (reset_n = 0 at a rising edge): rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0. All in-flight pipeline entries are cleared.
- INIT duration:
  - INIT lasts exactly DMEM_DEPTH/4 cycles after the first edge with reset_n = 1.
  - req_ready rises on the cycle after the last clear.
  - Reset asserted during INIT restarts the counter at 0.
- Response timing: a request accepted at edge N gives a response that is valid during the cycle after edge N+RD_LATENCY-1. In other words, RD_LATENCY = 1 means rsp_valid is high in the cycle immediately after acceptance.
- Throughput is one request per cycle in RUN.
- A load accepted in the cycle after a store to the same bytes returns the stored data. There is no hazard window.
- Reset in RUN drops all in-flight responses. None is emitted after reset. Memory is re-cleared through INIT.
- rsp_rdata and rsp_err hold 0 whenever rsp_valid = 0.

## Structure
- A shared package (risc_v_defines) holds:
  - the funct3 codes F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encodings ST_INIT and ST_RUN;
  - the default parameter values.
- Sub-module dmem_rsp_pipe: a RD_LATENCY-deep shift register of {valid, err, rdata}, with synchronous clear. The top level holds the array, the INIT FSM and counter, the decode/error logic, and the store byte-lane write.

## Test plan
- Reset then idle:
  - req_ready = 0 for exactly 256 cycles (DEPTH = 1024), then 1.
  - LW at 0x3FC then returns 0x00000000 with rsp_err = 0.
- SW 0x80FF7F01 @0x10, then LB, LBU, LH, LHU, LW @0x10/0x10/0x12/0x12/0x10 → responses 0x00000001, 0x00000001, 0xFFFF80FF, 0x000080FF, 0x80FF7F01.
- SB 0xAA @0x21 over a word holding 0x11223344 @0x20, then LW @0x20 → 0x1122AA44.
- LH @0x11, SW @0x12, LW @0x3FE, funct3 = 011 → each gives rsp_err = 1 and rsp_rdata = 0. A following LW @0x10 is unchanged.
- Back-to-back stream of 8 loads with RD_LATENCY = 3 → 8 consecutive rsp_valid pulses starting 3 cycles after the first accept, in order.
- reset_n low for one cycle while 2 responses are in flight → no rsp_valid afterwards, INIT repeats, and previously stored data reads back as 0.
